control_filtro: RTL and testbench
=================================

Name: control_filtro

Overview:
- Sequencer for the 25-bit Q-format biquad filter datapath: coefficient ROM, single shared multiplier and accumulator.
- On each sample tick it walks the five taps b0, b1, b2, a1, a2 through the shared multiplier.
- For each tap it drives the coefficient select and the data-operand select, and times the accumulator clear/enable around the multiplier latency.
- It then shifts the delay line and pulses done; one instance sits between the sample-rate generator and the filter datapath.

Parameters:
- MUL_LAT, 1, multiplier pipeline latency in clocks (1..4); acc_en lags the operand selects by this amount.
- N_TAPS, 5, taps per sample (fixed at 5; kept as a parameter for the tap counter width).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clock sample strobe from the sample-rate generator.
- en  in  1  filter enable; tick is ignored while low.
- clr_ovr  in  1  one-clock clear of the overrun flag.
- sel_cte  out  4  coefficient ROM select.
- sel_dato  out  3  operand select: 0=x[n], 1=x[n-1], 2=x[n-2], 3=y[n-1], 4=y[n-2].
- acc_clr  out  1  clear accumulator.
- acc_en  out  1  accumulate the multiplier output.
- shift_en  out  1  shift delay lines: x into x1, x1 into x2, acc into y1, y1 into y2.
- done  out  1  one-clock pulse: y[n] valid at the accumulator output.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tap counter=0, acc_en pipeline cleared.
  - All outputs 0; sel_cte=4'b0000, sel_dato=0.
- States: IDLE, CLR, ISSUE, DRAIN, UPDATE.
- IDLE: tick=1 and en=1 -> CLR. Otherwise stay.
- CLR (1 clk): acc_clr=1; tap=0 -> ISSUE.
- ISSUE (N_TAPS clks): drives sel_cte/sel_dato for the current tap, then tap++.
  - Tap map, in order: 0: cte 5, dato 0. 1: cte 6, dato 1. 2: cte 7, dato 2. 3: cte 1, dato 3. 4: cte 2, dato 4.
  - After tap 4 -> DRAIN.
- DRAIN (MUL_LAT clks): no new issue; selects hold the last tap.
- UPDATE (1 clk): shift_en=1, done=1 -> IDLE.
- acc_en is a MUL_LAT-deep delay of the "issuing" flag (high in ISSUE). It is therefore high for exactly 5 consecutive clocks, MUL_LAT clocks after the first issue.
- Latency: with the tick at clock 0, CLR is at clock 1, ISSUE at clocks 2..6, and done at clock 7+MUL_LAT (clock 8 for MUL_LAT=1).
- Outside ISSUE/DRAIN: sel_cte=0, sel_dato=0.
- Overrun:
  - tick=1 while busy=1 (this includes the UPDATE clock) sets overrun and the tick is dropped; the sequence in progress is not disturbed.
  - clr_ovr clears overrun. If set and clear happen in the same clock, set wins.
- en falling mid-sequence: the current sample completes; later ticks are ignored.
- Reset mid-sequence: immediate return to IDLE. No done or shift_en is produced, and the acc_en pipeline is flushed.
- All outputs are registered (Moore); no combinational path from input to output.

Decomposition:
- Shared include ctes_filtro.vh holds:
  - state encodings (3-bit);
  - tap-to-sel_cte map constants CTE_B0=5, CTE_B1=6, CTE_B2=7, CTE_A1=1, CTE_A2=2;
  - operand codes DATO_X0..DATO_Y2.
- One natural sub-module: retardo_en, a parameterised MUL_LAT-deep shift register with the same async active-low reset, producing acc_en.

Test Plan:
- Reset, then one tick with en=1, MUL_LAT=1:
  - acc_clr at clock 1;
  - sel_cte = 5,6,7,1,2 with sel_dato = 0..4 at clocks 2..6;
  - acc_en high clocks 3..7;
  - shift_en and done at clock 8; busy high clocks 1..8.
- MUL_LAT=3: acc_en high clocks 5..9, done at clock 10; sel_cte sequence unchanged.
- Second tick at clock 4 and another at clock 8 (UPDATE): overrun=1, no second acc_clr.
  - clr_ovr together with a new overrun tick: overrun stays 1.
  - clr_ovr alone: overrun=0.
- en=0 with tick: busy stays 0 and all outputs stay 0.
  - en dropped at clock 3: done still at clock 8.
- reset asserted at clock 4:
  - all outputs 0 immediately, no done or shift_en;
  - the next tick restarts cleanly from acc_clr.
- Back-to-back ticks spaced exactly 9 clocks apart (MUL_LAT=1): every sample completes and overrun stays 0.

Source files
------------

// File: rtl/control_filtro_pkg.sv
// rtl/control_filtro_pkg.sv - state encodings and tap maps for the biquad sequencer
package control_filtro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_UPDATE = 3'd4
    } estado_t;

    localparam logic [3:0] CTE_B0 = 4'd5;
    localparam logic [3:0] CTE_B1 = 4'd6;
    localparam logic [3:0] CTE_B2 = 4'd7;
    localparam logic [3:0] CTE_A1 = 4'd1;
    localparam logic [3:0] CTE_A2 = 4'd2;

    localparam logic [2:0] DATO_X0 = 3'd0;
    localparam logic [2:0] DATO_X1 = 3'd1;
    localparam logic [2:0] DATO_X2 = 3'd2;
    localparam logic [2:0] DATO_Y1 = 3'd3;
    localparam logic [2:0] DATO_Y2 = 3'd4;

    function automatic logic [3:0] cte_de_tap(input logic [2:0] tap);
        case (tap)
            3'd0:    return CTE_B0;
            3'd1:    return CTE_B1;
            3'd2:    return CTE_B2;
            3'd3:    return CTE_A1;
            3'd4:    return CTE_A2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] dato_de_tap(input logic [2:0] tap);
        case (tap)
            3'd0:    return DATO_X0;
            3'd1:    return DATO_X1;
            3'd2:    return DATO_X2;
            3'd3:    return DATO_Y1;
            3'd4:    return DATO_Y2;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/control_filtro_retardo_en.sv
// rtl/control_filtro_retardo_en.sv - MUL_LAT-deep delay of the issuing flag
module retardo_en #(
    parameter int MUL_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [MUL_LAT-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < MUL_LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[MUL_LAT-1];

endmodule

// File: rtl/control_filtro.sv
// rtl/control_filtro.sv - tap sequencer for the shared-multiplier biquad datapath
module control_filtro
    import control_filtro_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int N_TAPS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       en,
    input  logic       clr_ovr,
    output logic [3:0] sel_cte,
    output logic [2:0] sel_dato,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       shift_en,
    output logic       done,
    output logic       busy,
    output logic       overrun
);

    localparam int TAP_W = $clog2(N_TAPS);

    estado_t          estado, estado_nxt;
    logic [TAP_W-1:0] tap, tap_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic             ovr;
    logic             emitiendo;
    logic             selects_activos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= ST_IDLE;
            tap    <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            estado <= estado_nxt;
            tap    <= tap_nxt;
            cnt    <= cnt_nxt;
            // a dropped tick outranks a simultaneous clear
            if (tick && en && (estado != ST_IDLE)) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        estado_nxt = estado;
        tap_nxt    = tap;
        cnt_nxt    = cnt;
        case (estado)
            ST_IDLE: begin
                if (tick && en) begin
                    estado_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                tap_nxt    = '0;
                estado_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tap == TAP_W'(N_TAPS - 1)) begin
                    cnt_nxt    = '0;
                    estado_nxt = ST_DRAIN;
                end else begin
                    tap_nxt = tap + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt == 3'(MUL_LAT - 1)) begin
                    estado_nxt = ST_UPDATE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            ST_UPDATE: begin
                estado_nxt = ST_IDLE;
            end
            default: begin
                estado_nxt = ST_IDLE;
            end
        endcase
    end

    // outputs decode registered state only, so nothing from an input reaches them combinationally
    assign emitiendo       = (estado == ST_ISSUE);
    assign selects_activos = (estado == ST_ISSUE) || (estado == ST_DRAIN);
    assign sel_cte         = selects_activos ? cte_de_tap(3'(tap)) : 4'd0;
    assign sel_dato        = selects_activos ? dato_de_tap(3'(tap)) : 3'd0;
    assign acc_clr         = (estado == ST_CLR);
    assign shift_en        = (estado == ST_UPDATE);
    assign done            = (estado == ST_UPDATE);
    assign busy            = (estado != ST_IDLE);
    assign overrun         = ovr;

    retardo_en #(
        .MUL_LAT(MUL_LAT)
    ) u_retardo_en (
        .clk  (clk),
        .reset(reset),
        .d    (emitiendo),
        .q    (acc_en)
    );

endmodule

// File: tb/tb_control_filtro.sv
// tb/tb_control_filtro.sv - self-checking bench for control_filtro at MUL_LAT=1 and MUL_LAT=3
module tb_control_filtro;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, en, clr_ovr;
    logic [3:0] sel_cte  [2];
    logic [2:0] sel_dato [2];
    logic       acc_clr  [2];
    logic       acc_en   [2];
    logic       shift_en [2];
    logic       done     [2];
    logic       busy     [2];
    logic       overrun  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_filtro #(.MUL_LAT(1), .N_TAPS(5)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .en(en), .clr_ovr(clr_ovr),
        .sel_cte(sel_cte[0]), .sel_dato(sel_dato[0]), .acc_clr(acc_clr[0]),
        .acc_en(acc_en[0]), .shift_en(shift_en[0]), .done(done[0]),
        .busy(busy[0]), .overrun(overrun[0])
    );

    control_filtro #(.MUL_LAT(3), .N_TAPS(5)) dut3 (
        .clk(clk), .reset(reset), .tick(tick), .en(en), .clr_ovr(clr_ovr),
        .sel_cte(sel_cte[1]), .sel_dato(sel_dato[1]), .acc_clr(acc_clr[1]),
        .acc_en(acc_en[1]), .shift_en(shift_en[1]), .done(done[1]),
        .busy(busy[1]), .overrun(overrun[1])
    );

    // Reference: position within the sample timeline (0 = idle, 1 = clock after the tick)
    int lat [2]  = '{1, 3};
    int off [2]  = '{0, 0};
    bit ovrm [2] = '{0, 0};
    int ctes [5] = '{5, 6, 7, 1, 2};

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic t, input logic e, input logic c);
        for (int m = 0; m < 2; m++) begin
            bit bsy;
            bsy = (off[m] != 0);
            if (t && e && bsy) ovrm[m] = 1'b1;
            else if (c)        ovrm[m] = 1'b0;
            if (bsy)         off[m] = (off[m] == 7 + lat[m]) ? 0 : off[m] + 1;
            else if (t && e) off[m] = 1;
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            int o, l, tp, e_cte, e_dato;
            bit issue, drain;
            o     = off[m];
            l     = lat[m];
            issue = (o >= 2) && (o <= 6);
            drain = (o >= 7) && (o <= 6 + l);
            tp    = issue ? o - 2 : 4;
            e_cte  = (issue || drain) ? ctes[tp] : 0;
            e_dato = (issue || drain) ? tp : 0;
            cmp($sformatf("sel_cte_L%0d", l),  int'(sel_cte[m]),  e_cte);
            cmp($sformatf("sel_dato_L%0d", l), int'(sel_dato[m]), e_dato);
            cmp($sformatf("acc_clr_L%0d", l),  int'(acc_clr[m]),  int'(o == 1));
            cmp($sformatf("acc_en_L%0d", l),   int'(acc_en[m]),   int'((o >= 2 + l) && (o <= 6 + l)));
            cmp($sformatf("shift_en_L%0d", l), int'(shift_en[m]), int'(o == 7 + l));
            cmp($sformatf("done_L%0d", l),     int'(done[m]),     int'(o == 7 + l));
            cmp($sformatf("busy_L%0d", l),     int'(busy[m]),     int'(o != 0));
            cmp($sformatf("overrun_L%0d", l),  int'(overrun[m]),  int'(ovrm[m]));
        end
    endtask

    task automatic step(input logic t, input logic e, input logic c);
        tick    = t;
        en      = e;
        clr_ovr = c;
        @(posedge clk);
        #1;
        model_edge(t, e, c);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_mid();
        tick    = 1'b0;
        clr_ovr = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        off  = '{0, 0};
        ovrm = '{0, 0};
        check_model();
        @(posedge clk);
        #1;
        check_model();
        reset = 1'b1;
    endtask

    typedef struct {
        logic t, e, c;
        int   cte, dato, aclr, acc, dn, bsy;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // row i: inputs for clock i, outputs expected at clock i+1 (MUL_LAT=1)
        tbl[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 5, 0, 0, 0, 0, 1};
        tbl[2] = '{0, 1, 0, 6, 1, 0, 1, 0, 1};
        tbl[3] = '{0, 1, 0, 7, 2, 0, 1, 0, 1};
        tbl[4] = '{0, 1, 0, 1, 3, 0, 1, 0, 1};
        tbl[5] = '{0, 1, 0, 2, 4, 0, 1, 0, 1};
        tbl[6] = '{0, 1, 0, 2, 4, 0, 1, 0, 1};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

        reset   = 1'b0;
        tick    = 1'b0;
        en      = 1'b0;
        clr_ovr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model();
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].t, tbl[i].e, tbl[i].c);
            cmp($sformatf("tbl%0d_cte", i),   int'(sel_cte[0]),  tbl[i].cte);
            cmp($sformatf("tbl%0d_dato", i),  int'(sel_dato[0]), tbl[i].dato);
            cmp($sformatf("tbl%0d_clr", i),   int'(acc_clr[0]),  tbl[i].aclr);
            cmp($sformatf("tbl%0d_acc", i),   int'(acc_en[0]),   tbl[i].acc);
            cmp($sformatf("tbl%0d_done", i),  int'(done[0]),     tbl[i].dn);
            cmp($sformatf("tbl%0d_shift", i), int'(shift_en[0]), tbl[i].dn);
            cmp($sformatf("tbl%0d_busy", i),  int'(busy[0]),     tbl[i].bsy);
        end
        idle(4);

        // overrun: extra ticks at clock 4 and at the UPDATE clock 8
        for (int i = 0; i <= 8; i++) step(i == 0 || i == 4 || i == 8, 1'b1, 1'b0);
        cmp("ovr_set", int'(overrun[0]), 1);
        idle(4);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        cmp("ovr_set_wins", int'(overrun[0]), 1);
        idle(12);
        step(1'b0, 1'b1, 1'b1);
        cmp("ovr_cleared", int'(overrun[0]), 0);

        // tick with en low is ignored
        step(1'b1, 1'b0, 1'b0);
        cmp("en0_busy", int'(busy[0]), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // en dropped at clock 3: current sample still completes
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 3; i <= 12; i++) begin
            step(i == 6, 1'b0, 1'b0);
            if (i == 7) cmp("en_drop_done", int'(done[0]), 1);
        end

        // reset asserted during clock 4
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        reset_mid();
        idle(2);
        step(1'b1, 1'b1, 1'b0);
        cmp("restart_clr", int'(acc_clr[0]), 1);
        idle(12);

        // back-to-back ticks 9 clocks apart
        step(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            idle(8);
        end
        cmp("b2b_no_ovr", int'(overrun[0]), 0);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_mid();
            end else begin
                step($urandom_range(0, 5) == 0, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
